// File: rtl/tb_uart_pkg.sv
// tb_uart_pkg
// Shared constants and state types for the tb_uart endpoint.
//   DATA_BITS    : payload bits per 8N1 frame
//   LF / CR      : line-control bytes that the simulation log acts on
//   tx_state_t   : transmit FSM states
//   rx_state_t   : receive FSM states
//   is_printable : true for bytes the simulation log keeps in its line buffer
package tb_uart_pkg;

  localparam int         DATA_BITS = 8;
  localparam logic [7:0] LF        = 8'h0A;
  localparam logic [7:0] CR        = 8'h0D;

  // TX and RX share one package, so the state names carry a prefix to stay unique
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_CLEAR} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/tb_uart_rx.sv
// tb_uart_rx
// Receive half of the 8N1 endpoint: synchroniser, RX FSM and the simulation line log.
// Ports:
//   clock    in   system clock, posedge
//   resetb   in   asynchronous active-low reset
//   ser_rx   in   serial input from the chip TX, idle high
//   rx_data  out  last correctly framed byte
//   rx_valid out  one-cycle pulse when rx_data is updated
//   rx_error out  one-cycle pulse when the stop bit was sampled low
module tb_uart_rx
  import tb_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 347,
  parameter int LINE_MAX     = 64
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       ser_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_error
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int                BIT_W     = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  rx_state_t              rx_state;
  logic [CNT_W-1:0]       baud_cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic [DATA_BITS-1:0]   rx_shift;
  logic                   rx_meta;
  logic                   rx_sync;
  logic                   rx_prev;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  // All three reset high so the idle line never looks like a start edge.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= ser_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // After a framing error the line is usually still low; a new frame needs a
  // real high-to-low edge, so the edge detector alone re-arms on line high.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rx_state <= RX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            baud_cnt <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
            if (bit_cnt == BIT_LAST) begin
              rx_state <= RX_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            rx_state <= RX_IDLE;
            if (rx_sync) begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
            end else begin
              rx_error <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  localparam int IDX_W = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;

  logic [7:0] line_buf [LINE_MAX];
  int         line_len;

  // Simulation-only console log of the chip's text output, one line per LF.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      line_len <= 0;
    end else if (rx_error) begin
      $display("rx framing error");
    end else if (rx_valid) begin
      if (rx_data == LF) begin
        $write("rx: ");
        for (int i = 0; i < LINE_MAX; i++) begin
          if (i < line_len) $write("%c", line_buf[IDX_W'(i)]);
        end
        $write("\n");
        line_len <= 0;
      end else if (rx_data != CR && is_printable(rx_data)) begin
        if (line_len == LINE_MAX) begin
          $write("rx: ");
          for (int i = 0; i < LINE_MAX; i++) $write("%c", line_buf[IDX_W'(i)]);
          $write("\n");
          line_buf[0] <= rx_data;
          line_len    <= 1;
        end else begin
          line_buf[IDX_W'(line_len)] <= rx_data;
          line_len                   <= line_len + 1;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/tb_uart.sv
// tb_uart
// Clocked 8N1 UART endpoint facing the chip's UART pins. Holds the TX FSM and
// instantiates the receive path.
// Ports:
//   clock        in   system clock, posedge
//   resetb       in   asynchronous active-low reset
//   ser_rx       in   serial input from chip TX, idle high
//   ser_tx       out  serial output to chip RX, idle high
//   tx_start     in   level request to transmit tx_data
//   tx_data      in   byte to send, captured when the frame starts
//   tx_busy      out  high while a TX frame is on the line
//   tx_clear_req out  frame finished; requester must drop tx_start
//   rx_data      out  last received byte
//   rx_valid     out  one-cycle pulse: rx_data updated
//   rx_error     out  one-cycle pulse: framing error
module tb_uart
  import tb_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 347,
  parameter int LINE_MAX     = 64
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       ser_rx,
  output logic       ser_tx,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_clear_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_error
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int               BIT_W     = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

  tx_state_t            tx_state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 baud_done;

  assign baud_done = (baud_cnt == BAUD_LAST);

  // ser_tx is registered so each bit starts on a clock edge and lasts exactly
  // CLKS_PER_BIT cycles; CLEAR holds the requester off until tx_start drops,
  // which is what turns a held tx_start into a single frame.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      tx_state     <= TX_IDLE;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      tx_shift     <= '0;
      ser_tx       <= 1'b1;
      tx_busy      <= 1'b0;
      tx_clear_req <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_start && !tx_clear_req) begin
            tx_shift <= tx_data;
            ser_tx   <= 1'b0;
            tx_busy  <= 1'b1;
            baud_cnt <= '0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            ser_tx   <= tx_shift[0];
            tx_state <= TX_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              ser_tx   <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              bit_cnt  <= bit_cnt + 1'b1;
              tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
              ser_tx   <= tx_shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (baud_done) begin
            baud_cnt     <= '0;
            tx_busy      <= 1'b0;
            tx_clear_req <= 1'b1;
            tx_state     <= TX_CLEAR;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        TX_CLEAR: begin
          if (!tx_start) begin
            tx_clear_req <= 1'b0;
            tx_state     <= TX_IDLE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Simulation-only note when a frame has fully left the line.
  always_ff @(posedge clock) begin
    if (resetb && tx_state == TX_STOP && baud_done) $display("tx complete");
  end
`endif

  tb_uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .LINE_MAX     (LINE_MAX)
  ) u_rx (
    .clock    (clock),
    .resetb   (resetb),
    .ser_rx   (ser_rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_error (rx_error)
  );

endmodule

// File: tb/tb_tb_uart.sv
// tb_tb_uart
// Self-checking bench for tb_uart. Stimulus pushes expected bytes into queues;
// independent monitors decode the serial line and the RX outputs and compare.
module tb_tb_uart;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;

  logic       clock  = 1'b0;
  logic       resetb = 1'b0;
  logic       ser_rx = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       ser_tx;
  logic       tx_busy;
  logic       tx_clear_req;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_error;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } rx_exp_t;

  logic [7:0] tx_exp [$];
  rx_exp_t    rx_exp [$];
  logic [7:0] rx_last_good = 8'h00;

  int tests_run    = 0;
  int tests_failed = 0;

  tb_uart #(
    .CLKS_PER_BIT (CPB),
    .LINE_MAX     (64)
  ) dut (
    .clock        (clock),
    .resetb       (resetb),
    .ser_rx       (ser_rx),
    .ser_tx       (ser_tx),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .tx_clear_req (tx_clear_req),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_error     (rx_error)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference line decoder: samples ser_tx every cycle of a frame, requires each
  // bit to be constant for CPB cycles, and reads the value at each bit centre.
  initial begin : tx_monitor
    logic [9:0] bits;
    logic       cur;
    bit         steady;
    bit         aborted;
    logic [7:0] exp_b;
    forever begin
      @(negedge clock);
      if (resetb && ser_tx === 1'b0) begin
        steady  = 1'b1;
        aborted = 1'b0;
        cur     = 1'b0;
        bits    = '0;
        for (int c = 0; c < FRAME; c++) begin
          if (c > 0) @(negedge clock);
          if (!resetb) begin
            aborted = 1'b1;
            break;
          end
          if (c % CPB == 0) cur = ser_tx;
          else if (ser_tx !== cur) steady = 1'b0;
          if (c % CPB == CPB / 2) bits[c / CPB] = ser_tx;
        end
        if (!aborted) begin
          if (tx_exp.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL tx unexpected frame: got bits 0x%0h, expected no frame", bits);
          end else begin
            exp_b = tx_exp.pop_front();
            check_output("tx frame", {21'b0, bits, steady}, {21'b0, 1'b1, exp_b, 1'b0, 1'b1});
          end
        end
      end
    end
  end

  // RX output monitor: every rx_valid / rx_error pulse must match the next
  // expected event; framing errors must leave rx_data at the last good byte.
  initial begin : rx_monitor
    rx_exp_t e;
    forever begin
      @(negedge clock);
      if (!resetb) begin
        rx_last_good = 8'h00;
      end else begin
        if (rx_valid === 1'b1 || rx_error === 1'b1) begin
          if (rx_exp.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL rx unexpected event: got valid=%0b error=%0b data 0x%0h, expected none",
                     rx_valid, rx_error, rx_data);
          end else begin
            e = rx_exp.pop_front();
            if (e.is_err) begin
              check_output("rx framing error", {22'b0, rx_valid, rx_error, rx_data},
                           {22'b0, 1'b0, 1'b1, rx_last_good});
            end else begin
              check_output("rx byte", {22'b0, rx_valid, rx_error, rx_data},
                           {22'b0, 1'b1, 1'b0, e.data});
              rx_last_good = e.data;
            end
          end
        end
      end
    end
  end

  // Drive one 8N1 frame on ser_rx, each bit exactly CPB cycles.
  task automatic drive_rx(input logic [7:0] d, input bit stop_ok);
    logic [9:0] f;
    rx_exp_t    e;
    f        = {stop_ok, d, 1'b0};
    e.is_err = !stop_ok;
    e.data   = d;
    rx_exp.push_back(e);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      ser_rx = f[i];
      repeat (CPB - 1) @(negedge clock);
    end
  endtask

  // Request one byte with a held tx_start and release it once clear is requested.
  task automatic apply_stimulus(input logic [7:0] d);
    int n;
    @(negedge clock);
    tx_data  = d;
    tx_start = 1'b1;
    tx_exp.push_back(d);
    n = 0;
    while (tx_clear_req !== 1'b1 && n < FRAME + 10) begin
      @(negedge clock);
      n++;
    end
    check_output("tx clear_req raised", {31'b0, tx_clear_req}, 32'd1);
    tx_start = 1'b0;
    @(negedge clock);
    check_output("tx clear_req released", {31'b0, tx_clear_req}, 32'd0);
  endtask

  initial begin : watchdog
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int n;
    int hi;

    // Reset values
    repeat (3) @(negedge clock);
    check_output("reset ser_tx", {31'b0, ser_tx}, 32'd1);
    check_output("reset tx_busy", {31'b0, tx_busy}, 32'd0);
    check_output("reset tx_clear_req", {31'b0, tx_clear_req}, 32'd0);
    check_output("reset rx_data", {24'b0, rx_data}, 32'd0);
    check_output("reset rx_valid", {31'b0, rx_valid}, 32'd0);
    check_output("reset rx_error", {31'b0, rx_error}, 32'd0);
    resetb = 1'b1;
    repeat (3) @(negedge clock);

    // Single frame 0x61: one-cycle start latency, busy for exactly one frame
    @(negedge clock);
    tx_data  = 8'h61;
    tx_start = 1'b1;
    tx_exp.push_back(8'h61);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (tx_busy !== 1'b1 && n < 2);
    check_output("tx busy latency", n, 32'd1);
    hi = 1;
    while (hi < FRAME + 20) begin
      @(negedge clock);
      if (tx_busy !== 1'b1) break;
      hi++;
    end
    check_output("tx busy length", hi, FRAME);
    check_output("tx clear_req after frame", {31'b0, tx_clear_req}, 32'd1);
    repeat (5) @(negedge clock);
    check_output("tx clear_req held", {30'b0, tx_clear_req, ser_tx}, 32'd3);
    tx_start = 1'b0;
    @(negedge clock);
    check_output("tx clear_req drop", {31'b0, tx_clear_req}, 32'd0);

    // Held tx_start yields one frame; mid-frame tx_data change ignored
    @(negedge clock);
    tx_data  = 8'h0A;
    tx_start = 1'b1;
    tx_exp.push_back(8'h0A);
    repeat (FRAME / 2) @(negedge clock);
    tx_data = 8'($urandom);
    repeat (3 * FRAME - FRAME / 2) @(negedge clock);
    check_output("tx held clear/busy/line", {29'b0, tx_clear_req, tx_busy, ser_tx}, 32'b101);
    tx_start = 1'b0;
    @(negedge clock);
    check_output("tx held release", {31'b0, tx_clear_req}, 32'd0);

    // tx_start dropped mid-frame: frame completes, CLEAR lasts one cycle
    @(negedge clock);
    tx_data  = 8'($urandom);
    tx_start = 1'b1;
    tx_exp.push_back(tx_data);
    @(negedge clock);
    tx_start = 1'b0;
    n = 0;
    while (tx_busy !== 1'b0 && n < FRAME + 10) begin
      @(negedge clock);
      n++;
    end
    check_output("tx pulse clear_req", {30'b0, tx_busy, tx_clear_req}, 32'd1);
    @(negedge clock);
    check_output("tx pulse clear exit", {31'b0, tx_clear_req}, 32'd0);

    // RX back-to-back text "Hi\n"
    drive_rx(8'h48, 1'b1);
    drive_rx(8'h69, 1'b1);
    drive_rx(8'h0A, 1'b1);
    repeat (2 * CPB) @(negedge clock);

    // Framing error then a good frame
    drive_rx(8'h41, 1'b0);
    repeat (2 * CPB) @(negedge clock);
    ser_rx = 1'b1;
    repeat (2 * CPB) @(negedge clock);
    drive_rx(8'h42, 1'b1);
    repeat (2 * CPB) @(negedge clock);

    // Reset in the middle of TX and RX frames
    @(negedge clock);
    tx_data  = 8'h3C;
    tx_start = 1'b1;
    ser_rx   = 1'b0;
    repeat (CPB) @(negedge clock);
    ser_rx = 1'b1;
    repeat (4 * CPB) @(negedge clock);
    #2 resetb = 1'b0;
    #1 check_output("async reset ser_tx/busy", {30'b0, ser_tx, tx_busy}, 32'b10);
    tx_start = 1'b0;
    repeat (3) @(negedge clock);
    check_output("reset rx_data cleared", {24'b0, rx_data}, 32'd0);
    resetb = 1'b1;
    repeat (3) @(negedge clock);
    apply_stimulus(8'($urandom));

    // Concurrent TX 0x55 / RX 0xAA, then a short glitch on the idle line
    fork
      apply_stimulus(8'h55);
      drive_rx(8'hAA, 1'b1);
    join
    @(negedge clock);
    ser_rx = 1'b0;
    repeat (CPB / 4) @(negedge clock);
    ser_rx = 1'b1;
    repeat (FRAME) @(negedge clock);

    // Random concurrent traffic
    for (int k = 0; k < 12; k++) begin
      fork
        apply_stimulus(8'($urandom));
        begin
          repeat ($urandom_range(0, 3 * CPB)) @(negedge clock);
          drive_rx(8'($urandom), 1'b1);
        end
      join
    end

    // All expected traffic must have been observed
    repeat (2 * FRAME) @(negedge clock);
    check_output("tx frames outstanding", tx_exp.size(), 32'd0);
    check_output("rx events outstanding", rx_exp.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
